// File: rtl/gt_common_rst_pkg.sv
// Shared types for the GTP common PLL reset sequencer: per-PLL state encoding,
// retry counter width and the Moore output decode used by the top level.
package gt_common_rst_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        ST_PD        = 3'd0,
        ST_PD_EXIT   = 3'd1,
        ST_RESET     = 3'd2,
        ST_WAIT_LOCK = 3'd3,
`ifdef GT_PLL_LOCK_DEBOUNCE_EN
        ST_STABLE    = 3'd4,
`endif
        ST_READY     = 3'd5,
        ST_FAIL      = 3'd6
    } pll_rst_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Returns {pd, reset, ready, fail} for a state.
    function automatic logic [3:0] pll_rst_outs(input pll_rst_state_t s);
        case (s)
            ST_PD:                return 4'b1100;
            ST_PD_EXIT, ST_RESET: return 4'b0100;
            ST_READY:             return 4'b0010;
            ST_FAIL:              return 4'b0101;
            default:              return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/gt_pll_rst_fsm.sv
// One PLL's lock/refclk-lost synchronizer, phase/timeout counters and
// power-up/reset/lock-wait/retry FSM. GT_PLL_LOCK_DEBOUNCE_EN adds lock debounce.
module gt_pll_rst_fsm
    import gt_common_rst_pkg::*;
#(
    parameter int RESET_CYCLES       = 16,
    parameter int PD_SETTLE_CYCLES   = 32,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                pd_req_i,
    input  logic                restart_i,
    input  logic                lock_i,
    input  logic                refclk_lost_i,
    output pll_rst_state_t      state_o,
    output logic [RETRY_W-1:0]  retry_cnt_o
);

    localparam int PH_N  = (PD_SETTLE_CYCLES > RESET_CYCLES) ? PD_SETTLE_CYCLES : RESET_CYCLES;
    localparam int PH_W  = cnt_w(PH_N);
    localparam int TMO_W = cnt_w(LOCK_TIMEOUT);
    localparam logic [PH_W-1:0]  PD_LAST  = PH_W'(PD_SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]  RST_LAST = PH_W'(RESET_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);

    if (RESET_CYCLES < 2) begin : g_bad_reset_cycles
        $error("RESET_CYCLES must be at least 2");
    end
    if (PD_SETTLE_CYCLES < 1) begin : g_bad_pd_settle
        $error("PD_SETTLE_CYCLES must be at least 1");
    end
    if (LOCK_TIMEOUT < 2) begin : g_bad_lock_timeout
        $error("LOCK_TIMEOUT must be at least 2");
    end
    if (LOCK_STABLE_CYCLES < 1) begin : g_bad_lock_stable
        $error("LOCK_STABLE_CYCLES must be at least 1");
    end
    if (MAX_RETRIES < 0) begin : g_bad_max_retries
        $error("MAX_RETRIES must not be negative");
    end

    logic [1:0]         sync_lock_q;
    logic [1:0]         sync_lost_q;
    pll_rst_state_t     state_q;
    logic [PH_W-1:0]    phase_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [RETRY_W-1:0] retry_q;
`ifdef GT_PLL_LOCK_DEBOUNCE_EN
    localparam int STB_W = cnt_w(LOCK_STABLE_CYCLES);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
    logic [STB_W-1:0]   stb_q;
`endif

    logic               good;
    logic               tmo_hit;
    logic               to_fail;
    logic [RETRY_W-1:0] retry_inc;

    // Both raw PLL status lines are asynchronous to clk.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_lock_q <= '0;
            sync_lost_q <= '0;
        end else begin
            sync_lock_q <= {sync_lock_q[0], lock_i};
            sync_lost_q <= {sync_lost_q[0], refclk_lost_i};
        end
    end

    always_comb begin
        good      = sync_lock_q[1] & ~sync_lost_q[1];
        tmo_hit   = (tmo_q == TMO_LAST);
        retry_inc = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
        to_fail   = (MAX_RETRIES != 0) && (int'(retry_inc) == MAX_RETRIES);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RESET;
            phase_q <= '0;
            tmo_q   <= '0;
            retry_q <= '0;
`ifdef GT_PLL_LOCK_DEBOUNCE_EN
            stb_q   <= '0;
`endif
        end else if (pd_req_i) begin
            state_q <= ST_PD;
            phase_q <= '0;
        end else if (restart_i) begin
            state_q <= ST_RESET;
            phase_q <= '0;
            retry_q <= '0;
        end else begin
            case (state_q)
                ST_PD: begin
                    state_q <= ST_PD_EXIT;
                    phase_q <= '0;
                end
                ST_PD_EXIT: begin
                    if (phase_q == PD_LAST) begin
                        state_q <= ST_RESET;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end
                ST_RESET: begin
                    if (phase_q == RST_LAST) begin
                        state_q <= ST_WAIT_LOCK;
                        tmo_q   <= '0;
`ifdef GT_PLL_LOCK_DEBOUNCE_EN
                        stb_q   <= '0;
`endif
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    tmo_q <= tmo_q + TMO_W'(1);
                    if (tmo_hit) begin
                        retry_q <= retry_inc;
                        state_q <= to_fail ? ST_FAIL : ST_RESET;
                        phase_q <= '0;
                    end else if (good) begin
`ifdef GT_PLL_LOCK_DEBOUNCE_EN
                        state_q <= ST_STABLE;
                        stb_q   <= '0;
`else
                        state_q <= ST_READY;
`endif
                    end
                end
`ifdef GT_PLL_LOCK_DEBOUNCE_EN
                // The timeout keeps running across debounce glitches.
                ST_STABLE: begin
                    tmo_q <= tmo_q + TMO_W'(1);
                    if (tmo_hit) begin
                        retry_q <= retry_inc;
                        state_q <= to_fail ? ST_FAIL : ST_RESET;
                        phase_q <= '0;
                    end else if (!good) begin
                        state_q <= ST_WAIT_LOCK;
                        stb_q   <= '0;
                    end else if (stb_q == STB_LAST) begin
                        state_q <= ST_READY;
                    end else begin
                        stb_q <= stb_q + STB_W'(1);
                    end
                end
`endif
                ST_READY: begin
                    if (!good) begin
                        state_q <= ST_RESET;
                        phase_q <= '0;
                    end
                end
                ST_FAIL: begin
                    state_q <= ST_FAIL;
                end
                default: begin
                    state_q <= ST_RESET;
                    phase_q <= '0;
                end
            endcase
        end
    end

    assign state_o     = state_q;
    assign retry_cnt_o = retry_q;

endmodule

// File: rtl/gt_common_pll_rst_seq.sv
// Power-down/reset sequencer for both GTP common PLLs (PLL0 = PCIe, PLL1 = SFP).
// Define GT_PLL_LOCK_DEBOUNCE_EN to require LOCK_STABLE_CYCLES of stable lock before ready.
module gt_common_pll_rst_seq
    import gt_common_rst_pkg::*;
#(
    parameter int RESET_CYCLES       = 16,
    parameter int PD_SETTLE_CYCLES   = 32,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               pll_pd_req,
    input  logic [1:0]               pll_restart,
    input  logic [1:0]               pll_lock,
    input  logic [1:0]               pll_refclk_lost,
    output logic [1:0]               pll_pd,
    output logic [1:0]               pll_reset,
    output logic [1:0]               pll_ready,
    output logic [1:0]               pll_fail,
    output logic [1:0][RETRY_W-1:0]  pll_retry_cnt
);

    pll_rst_state_t pll_state [2];

    for (genvar g = 0; g < 2; g++) begin : g_pll
        gt_pll_rst_fsm #(
            .RESET_CYCLES       (RESET_CYCLES),
            .PD_SETTLE_CYCLES   (PD_SETTLE_CYCLES),
            .LOCK_TIMEOUT       (LOCK_TIMEOUT),
            .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
            .MAX_RETRIES        (MAX_RETRIES)
        ) u_fsm (
            .clk_i         (clk),
            .rst_i         (rst),
            .pd_req_i      (pll_pd_req[g]),
            .restart_i     (pll_restart[g]),
            .lock_i        (pll_lock[g]),
            .refclk_lost_i (pll_refclk_lost[g]),
            .state_o       (pll_state[g]),
            .retry_cnt_o   (pll_retry_cnt[g])
        );

        // Outputs depend on registered state only.
        assign {pll_pd[g], pll_reset[g], pll_ready[g], pll_fail[g]} = pll_rst_outs(pll_state[g]);
    end

endmodule

// File: tb/tb_gt_common_pll_rst_seq.sv
// Scenario bench for gt_common_pll_rst_seq: expected per-PLL output snapshots are
// queued by cycle when stimulus is driven and compared when that cycle is reached.
`timescale 1ns/1ps
module tb_gt_common_pll_rst_seq;

    localparam int RC  = 4;
    localparam int PS  = 8;
    localparam int LT  = 100;
    localparam int LSC = 10;
    localparam int MR  = 3;
`ifdef GT_PLL_LOCK_DEBOUNCE_EN
    localparam int RDY_LAT = 1 + LSC;
`else
    localparam int RDY_LAT = 1;
`endif
    // Queue entry: {cycle[15:0], pll, pd, reset, ready, fail, retry[3:0]}
    localparam int W = 25;

    localparam logic [7:0] S_PD    = 8'b1100_0000;
    localparam logic [7:0] S_RST   = 8'b0100_0000;
    localparam logic [7:0] S_IDLE  = 8'b0000_0000;
    localparam logic [7:0] S_READY = 8'b0010_0000;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       pll_pd_req = '0;
    logic [1:0]       pll_restart = '0;
    logic [1:0]       pll_lock = '0;
    logic [1:0]       pll_refclk_lost = '0;
    logic [1:0]       pll_pd;
    logic [1:0]       pll_reset;
    logic [1:0]       pll_ready;
    logic [1:0]       pll_fail;
    logic [1:0][3:0]  pll_retry_cnt;

    always #5 clk = ~clk;

    gt_common_pll_rst_seq #(
        .RESET_CYCLES       (RC),
        .PD_SETTLE_CYCLES   (PS),
        .LOCK_TIMEOUT       (LT),
        .LOCK_STABLE_CYCLES (LSC),
        .MAX_RETRIES        (MR)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pll_pd_req      (pll_pd_req),
        .pll_restart     (pll_restart),
        .pll_lock        (pll_lock),
        .pll_refclk_lost (pll_refclk_lost),
        .pll_pd          (pll_pd),
        .pll_reset       (pll_reset),
        .pll_ready       (pll_ready),
        .pll_fail        (pll_fail),
        .pll_retry_cnt   (pll_retry_cnt)
    );

    // Cycle 0 is the first cycle with rst low.
    int cyc = 0;
    bit run = 1'b0;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] mon_e;
    string        mon_t;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic expect_at(input int c, input int p, input logic [7:0] v, input string tag);
        int i = 0;
        while (i < exp_q.size() && int'(exp_q[i][W-1:9]) <= c) i++;
        exp_q.insert(i, {16'(c), 1'(p), v});
        tag_q.insert(i, tag);
    endtask

    function automatic logic [7:0] snap(input int p);
        return {pll_pd[p], pll_reset[p], pll_ready[p], pll_fail[p], pll_retry_cnt[p]};
    endfunction

    always @(negedge clk) begin
        if (run) begin
            while (exp_q.size() > 0 && int'(exp_q[0][W-1:9]) == cyc) begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                check_eq(mon_t, snap(int'(mon_e[8])), mon_e[7:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic at_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        pll_lock = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run = 1'b1;

        // Power-on: PLL0 locks, PLL1 never does and exhausts its retries.
        expect_at(0,            0, S_RST,   "p0_por_reset_first");
        expect_at(RC - 1,       0, S_RST,   "p0_por_reset_last");
        expect_at(RC,           0, S_IDLE,  "p0_por_wait");
        expect_at(RC + RDY_LAT - 1, 0, S_IDLE, "p0_por_not_ready");
        expect_at(RC + RDY_LAT, 0, S_READY, "p0_por_ready");
        expect_at(0,            1, S_RST,   "p1_por_reset");
        expect_at(RC,           1, S_IDLE,  "p1_wait1");
        expect_at(RC + LT - 1,  1, S_IDLE,  "p1_before_to1");
        expect_at(RC + LT,      1, 8'b0100_0001, "p1_retry1_reset");
        expect_at(RC + LT + RC - 1, 1, 8'b0100_0001, "p1_retry1_reset_end");
        expect_at(2 * RC + LT,  1, 8'b0000_0001, "p1_wait2");
        expect_at(2 * (RC + LT), 1, 8'b0100_0010, "p1_retry2_reset");
        expect_at(3 * (RC + LT) - 1, 1, 8'b0000_0010, "p1_before_fail");
        expect_at(3 * (RC + LT), 1, 8'b0101_0011, "p1_fail");
        expect_at(320,          1, 8'b0101_0011, "p1_fail_held");

        // One-cycle raw lock drop on PLL0 while ready.
        at_cyc(30);
        pll_lock[0] = 1'b0;
        expect_at(32, 0, S_READY, "p0_drop_still_ready");
        expect_at(33, 0, S_RST,   "p0_drop_reset");
        expect_at(36, 0, S_RST,   "p0_drop_reset_end");
        expect_at(37, 0, S_IDLE,  "p0_drop_wait");
        expect_at(37 + RDY_LAT - 1, 0, S_IDLE, "p0_relock_not_ready");
        expect_at(37 + RDY_LAT, 0, S_READY, "p0_relock_ready");
        at_cyc(31);
        pll_lock[0] = 1'b1;

        // Power-down PLL0 while ready, then release.
        at_cyc(60);
        pll_pd_req[0] = 1'b1;
        expect_at(60, 0, S_READY, "p0_pd_req_cycle");
        expect_at(61, 0, S_PD,    "p0_pd");
        expect_at(70, 0, S_PD,    "p0_pd_held");
        expect_at(71, 0, S_RST,   "p0_pd_exit");
        expect_at(70 + PS, 0, S_RST, "p0_pd_exit_end");
        expect_at(71 + PS, 0, S_RST, "p0_pd_reset");
        expect_at(70 + PS + RC, 0, S_RST, "p0_pd_reset_end");
        expect_at(71 + PS + RC, 0, S_IDLE, "p0_pd_wait");
`ifdef GT_PLL_LOCK_DEBOUNCE_EN
        // Refclk-lost glitch at stable count 5 restarts the debounce.
        expect_at(94,  0, S_IDLE,  "p0_glitch_no_early_ready");
        expect_at(102, 0, S_IDLE,  "p0_glitch_not_ready");
        expect_at(103, 0, S_READY, "p0_glitch_ready");
`else
        expect_at(83 + RDY_LAT - 1, 0, S_IDLE, "p0_pd_not_ready");
        expect_at(83 + RDY_LAT, 0, S_READY, "p0_pd_ready");
`endif
        at_cyc(70);
        pll_pd_req[0] = 1'b0;
`ifdef GT_PLL_LOCK_DEBOUNCE_EN
        at_cyc(89);
        pll_refclk_lost[0] = 1'b1;
        at_cyc(90);
        pll_refclk_lost[0] = 1'b0;
`endif

        // Restart PLL1 out of FAIL.
        at_cyc(330);
        pll_restart[1] = 1'b1;
        expect_at(330, 1, 8'b0101_0011, "p1_restart_cycle");
        expect_at(331, 1, S_RST,  "p1_restart_reset");
        expect_at(334, 1, S_RST,  "p1_restart_reset_end");
        expect_at(335, 1, S_IDLE, "p1_restart_wait");
        expect_at(345, 1, S_IDLE, "p1_restart_wait_retry0");
        at_cyc(331);
        pll_restart[1] = 1'b0;

        // Restart coincident with power-down: power-down wins.
        at_cyc(350);
        pll_pd_req[1]  = 1'b1;
        pll_restart[1] = 1'b1;
        expect_at(351, 1, S_PD,   "p1_pd_wins");
        expect_at(356, 1, S_PD,   "p1_pd_held");
        expect_at(357, 1, S_RST,  "p1_pd_exit");
        expect_at(356 + PS, 1, S_RST, "p1_pd_exit_end");
        expect_at(357 + PS, 1, S_RST, "p1_pd_reset");
        expect_at(356 + PS + RC, 1, S_RST, "p1_pd_reset_end");
        expect_at(357 + PS + RC, 1, S_IDLE, "p1_pd_wait");
        expect_at(356 + PS + RC + RDY_LAT, 1, S_IDLE, "p1_lock_not_ready");
        expect_at(357 + PS + RC + RDY_LAT, 1, S_READY, "p1_lock_ready");
        expect_at(360, 0, S_READY, "p0_independent");
        at_cyc(351);
        pll_restart[1] = 1'b0;
        at_cyc(356);
        pll_pd_req[1] = 1'b0;
        pll_lock[1]   = 1'b1;

        at_cyc(400);
        @(negedge clk);
        #1;
        check_eq("sb_drained", 8'(exp_q.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
